// File: rtl/max7219_slave_pkg.sv
// Shared constants for the MAX7219 receiver: register map, FSM state type and defaults.
package max7219_pkg;

    localparam int unsigned FRAME_BITS_DEFAULT  = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT1    = 4'h2;
    localparam logic [3:0] REG_DIGIT2    = 4'h3;
    localparam logic [3:0] REG_DIGIT3    = 4'h4;
    localparam logic [3:0] REG_DIGIT4    = 4'h5;
    localparam logic [3:0] REG_DIGIT5    = 4'h6;
    localparam logic [3:0] REG_DIGIT6    = 4'h7;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/max7219_slave_if.sv
// SPI link pins between the face-pattern controller (master) and the MAX7219 model (slave).
interface max7219_slave_if;
    logic sclk;
    logic mosi;
    logic cs;
    logic dout;

    modport master (output sclk, output mosi, output cs, input dout);
    modport slave  (input sclk, input mosi, input cs, output dout);
endinterface

// File: rtl/max7219_slave_sync.sv
// N-stage synchronizer for sclk/mosi/cs with edge pulses on sclk and cs.
module spi_slave_sync
    import max7219_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic mosi,
    input  logic cs,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [STAGES-1:0] sclk_q;
    logic [STAGES-1:0] mosi_q;
    logic [STAGES-1:0] cs_q;
    logic              sclk_prev;
    logic              cs_prev;

    // cs chain clears to 0 so a cs held low through reset release never looks like a fall
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q    <= '0;
            mosi_q    <= '0;
            cs_q      <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_q[0] <= sclk;
            mosi_q[0] <= mosi;
            cs_q[0]   <= cs;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sclk_q[i] <= sclk_q[i-1];
                mosi_q[i] <= mosi_q[i-1];
                cs_q[i]   <= cs_q[i-1];
            end
            sclk_prev <= sclk_q[STAGES-1];
            cs_prev   <= cs_q[STAGES-1];
        end
    end

    assign mosi_s    = mosi_q[STAGES-1];
    assign sclk_rise =  sclk_q[STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_q[STAGES-1] &  sclk_prev;
    assign cs_rise   =  cs_q[STAGES-1]   & ~cs_prev;
    assign cs_fall   = ~cs_q[STAGES-1]   &  cs_prev;

endmodule

// File: rtl/max7219_slave.sv
// MAX7219 model: LOAD-framed SPI receiver, register decode and 8x8 frame buffer with row readout.
module max7219_slave
    import max7219_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    max7219_slave_if.slave        spi,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [3:0]            frame_addr,
    output logic [7:0]            frame_data,
    output logic                  shutdown_n,
    output logic [7:0]            decode_mode,
    output logic [3:0]            intensity,
    output logic [2:0]            scan_limit,
    output logic                  display_test,
    input  logic [2:0]            row_sel,
    output logic [7:0]            row_data
);

    localparam logic [5:0] FRAME_LIMIT = 6'(FRAME_BITS);

    logic       mosi_s;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_rise;
    logic       cs_fall;

    state_t     state;
    logic [15:0] sr;
    logic [4:0]  bit_cnt;
    logic        dout_q;
    logic [7:0]  rows [8];
    logic [2:0]  row_idx;

    spi_slave_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (spi.sclk),
        .mosi      (spi.mosi),
        .cs        (spi.cs),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall)
    );

    // digit addresses 1..8 map to rows 0..7; the low three address bits minus one wrap 8 onto 7
    assign row_idx  = sr[10:8] - 3'd1;
    assign spi.dout = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sr           <= '0;
            bit_cnt      <= '0;
            dout_q       <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
            shutdown_n   <= 1'b0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            display_test <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                rows[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        sr <= {sr[14:0], mosi_s};
                        if (bit_cnt != '1) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    if (sclk_fall) begin
                        dout_q <= sr[15];
                    end
                    if (cs_rise) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    state <= IDLE;
                    if ({1'b0, bit_cnt} < FRAME_LIMIT) begin
                        frame_err <= 1'b1;
                    end else begin
                        frame_valid <= 1'b1;
                        frame_addr  <= sr[11:8];
                        frame_data  <= sr[7:0];
                        case (sr[11:8])
                            REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
                            REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
                                rows[row_idx] <= sr[7:0];
                            REG_DECODE:    decode_mode  <= sr[7:0];
                            REG_INTENSITY: intensity    <= sr[3:0];
                            REG_SCANLIM:   scan_limit   <= sr[2:0];
                            REG_SHUTDOWN:  shutdown_n   <= sr[0];
                            REG_TEST:      display_test <= sr[0];
                            REG_NOOP:      ;
                            default:       ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        row_data = '0;
        if (display_test) begin
            row_data = 8'hFF;
        end else if (shutdown_n && (row_sel <= scan_limit)) begin
            row_data = rows[row_sel];
        end
    end

endmodule

// File: tb/tb_max7219_slave.sv
// Bench for max7219_slave: directed display scenarios plus random frames against a register-map model.
module tb_max7219_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_valid;
    logic       frame_err;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic       shutdown_n;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       display_test;
    logic [2:0] row_sel;
    logic [7:0] row_data;

    always #5 clk = ~clk;

    max7219_slave_if spi ();

    max7219_slave #(
        .FRAME_BITS  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .frame_addr   (frame_addr),
        .frame_data   (frame_data),
        .shutdown_n   (shutdown_n),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .display_test (display_test),
        .row_sel      (row_sel),
        .row_data     (row_data)
    );

    // reference model of the visible register state
    logic [7:0] m_row [8];
    logic       m_shdn;
    logic [7:0] m_dec;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_test;
    logic [3:0] m_addr;
    logic [7:0] m_data;

    int n_vec = 0;
    int n_bad = 0;
    int total_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_row[i] = 8'h00;
        m_shdn = 0; m_dec = 0; m_int = 0; m_scan = 0; m_test = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_apply(input logic [15:0] w);
        logic [3:0] a;
        logic [7:0] d;
        a = w[11:8];
        d = w[7:0];
        m_addr = a;
        m_data = d;
        if (a >= 4'd1 && a <= 4'd8) m_row[a - 4'd1] = d;
        else if (a == 4'h9) m_dec = d;
        else if (a == 4'hA) m_int = d[3:0];
        else if (a == 4'hB) m_scan = d[2:0];
        else if (a == 4'hC) m_shdn = d[0];
        else if (a == 4'hF) m_test = d[0];
    endtask

    function automatic logic [7:0] exp_row(input int sel);
        if (m_test) return 8'hFF;
        if (!m_shdn) return 8'h00;
        if (sel > int'(m_scan)) return 8'h00;
        return m_row[sel];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_regs(input string ctx);
        check({ctx, ".frame_addr"},   32'(frame_addr),   32'(m_addr));
        check({ctx, ".frame_data"},   32'(frame_data),   32'(m_data));
        check({ctx, ".shutdown_n"},   32'(shutdown_n),   32'(m_shdn));
        check({ctx, ".decode_mode"},  32'(decode_mode),  32'(m_dec));
        check({ctx, ".intensity"},    32'(intensity),    32'(m_int));
        check({ctx, ".scan_limit"},   32'(scan_limit),   32'(m_scan));
        check({ctx, ".display_test"}, 32'(display_test), 32'(m_test));
        for (int r = 0; r < 8; r++) begin
            row_sel = 3'(r);
            #1;
            check($sformatf("%s.row%0d", ctx, r), 32'(row_data), 32'(exp_row(r)));
        end
    endtask

    // one sclk period: mosi set during the low phase, dout sampled just before the rise
    task automatic spi_bit(input logic b, output logic d);
        spi.mosi = b;
        wait_clk(4);
        d = spi.dout;
        spi.sclk = 1'b1;
        wait_clk(4);
        spi.sclk = 1'b0;
    endtask

    // observe the 8 cycles after cs rises; the pulse is due on the 4th
    task automatic watch_pulses(output int nv, output int ne, output int at);
        nv = 0; ne = 0; at = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin nv++; at = i; end
            if (frame_err === 1'b1)   begin ne++; at = i; end
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits, output logic [31:0] dq);
        int nv, ne, at;
        logic d;
        dq = '0;
        spi.cs = 1'b0;
        wait_clk(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(word[i], d);
            dq = {dq[30:0], d};
        end
        wait_clk(4);
        spi.cs = 1'b1;
        watch_pulses(nv, ne, at);
        total_valid += nv;
        if (nbits < 16) begin
            check("err_pulse", 32'(ne), 32'd1);
            check("no_valid_on_short", 32'(nv), 32'd0);
        end else begin
            check("valid_pulse", 32'(nv), 32'd1);
            check("no_err_on_full", 32'(ne), 32'd0);
            model_apply(word[15:0]);
        end
        check("pulse_latency", 32'(at), 32'd4);
        check_regs($sformatf("frame_%0h_%0d", word, nbits));
    endtask

    initial begin
        logic [31:0] dq;
        logic        d;
        int          nv, ne, at;

        reset = 1'b1;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        spi.cs   = 1'b1;
        row_sel  = 3'd0;
        model_reset();
        wait_clk(4);
        reset = 1'b0;
        wait_clk(4);
        check("reset.frame_valid", 32'(frame_valid), 32'd0);
        check("reset.frame_err",   32'(frame_err),   32'd0);
        check("reset.dout",        32'(spi.dout),    32'd0);
        check_regs("reset");

        // boot sequence
        total_valid = 0;
        send_frame(32'h0C01, 16, dq);
        send_frame(32'h0900, 16, dq);
        send_frame(32'h0A0A, 16, dq);
        send_frame(32'h0B07, 16, dq);
        send_frame(32'h0F00, 16, dq);
        check("boot.valid_count", 32'(total_valid), 32'd5);
        check("boot.intensity",   32'(intensity),   32'hA);
        check("boot.scan_limit",  32'(scan_limit),  32'd7);

        // happy face
        send_frame(32'h01FF, 16, dq);
        send_frame(32'h0281, 16, dq);
        send_frame(32'h03A5, 16, dq);
        send_frame(32'h0481, 16, dq);
        send_frame(32'h05A5, 16, dq);
        send_frame(32'h0699, 16, dq);
        send_frame(32'h0781, 16, dq);
        send_frame(32'h08FF, 16, dq);
        row_sel = 3'd5;
        #1;
        check("face.row5", 32'(row_data), 32'h99);

        // short and long frames
        send_frame(32'h0A05, 12, dq);
        send_frame(32'hAB0A03, 24, dq);
        check("long.intensity",  32'(intensity),  32'd3);
        check("long.frame_addr", 32'(frame_addr), 32'hA);

        // gating
        send_frame(32'h0B02, 16, dq);
        row_sel = 3'd5;
        #1;
        check("gate.scan_row5", 32'(row_data), 32'h00);
        send_frame(32'h0F01, 16, dq);
        send_frame(32'h0C00, 16, dq);
        send_frame(32'h0F00, 16, dq);
        send_frame(32'h0C01, 16, dq);
        send_frame(32'h0B07, 16, dq);

        // reset mid-frame, then the rest of a frame with no fresh cs fall
        spi.cs = 1'b0;
        wait_clk(4);
        for (int i = 15; i >= 7; i--) spi_bit(dq[i], d);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        model_reset();
        wait_clk(2);
        check_regs("midreset");
        for (int i = 15; i >= 0; i--) begin
            logic [15:0] w;
            w = 16'h0A05;
            spi_bit(w[i], d);
        end
        wait_clk(4);
        spi.cs = 1'b1;
        watch_pulses(nv, ne, at);
        check("midreset.no_valid", 32'(nv), 32'd0);
        check("midreset.no_err",   32'(ne), 32'd0);
        check("midreset.intensity", 32'(intensity), 32'd0);
        send_frame(32'h0A06, 16, dq);
        send_frame(32'h0C01, 16, dq);
        send_frame(32'h0B07, 16, dq);

        // daisy chain
        send_frame(32'h0C01_0A07, 32, dq);
        check("daisy.dout", 32'(dq[15:0]), 32'h0C01);

        // random frames
        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            int          nb;
            int          r;
            w = $urandom;
            w[11:8] = 4'($urandom_range(0, 15));
            if (w[11:8] == 4'hF) w[0] = ($urandom_range(0, 3) == 0);
            if (w[11:8] == 4'hC) w[0] = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 6)      nb = 16;
            else if (r < 8) nb = $urandom_range(1, 15);
            else            nb = $urandom_range(17, 31);
            send_frame(w, nb, dq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
